// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves IF fetches and MEM loads/stores over one 8-bit RAM port.
// Define MEMCTRL_MISALIGN_CHK_EN to add mem_misalign_o and reject misaligned MEM accesses.
module mem_ctrl #(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req_i,
  input  logic [31:0]               if_addr_i,
  output logic                      if_busy_o,
  output logic                      if_done_o,
  output logic [31:0]               if_inst_o,
  input  logic                      mem_req_i,
  input  logic                      mem_we_i,
  input  logic [1:0]                mem_len_i,
  input  logic                      mem_signed_i,
  input  logic [31:0]               mem_addr_i,
  input  logic [31:0]               mem_wdata_i,
  output logic                      mem_busy_o,
  output logic                      mem_done_o,
  output logic [31:0]               mem_rdata_o,
`ifdef MEMCTRL_MISALIGN_CHK_EN
  output logic                      mem_misalign_o,
`endif
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic                      ram_wr_o,
  output logic [7:0]                ram_dout_o,
  input  logic [7:0]                ram_din_i
);

  typedef enum logic [2:0] {
    IDLE,
    IF_RD,
    MEM_RD,
    MEM_WR,
    DONE
  } state_t;

  state_t      state;
  logic [2:0]  count;
  logic [2:0]  n_bytes;
  logic [2:0]  mem_n;
  logic [31:0] cur_addr;
  logic [31:0] next_addr;
  logic [31:0] rbuf;
  logic [31:0] rword;
  logic [31:0] rext;
  logic [23:0] wdata_q;
  logic        sgn_q;

  assign if_busy_o  = if_req_i && !if_done_o;
  assign mem_busy_o = mem_req_i && !mem_done_o;
  assign next_addr  = cur_addr + 32'd1;

  always_comb begin
    case (mem_len_i)
      2'd0:    mem_n = 3'd1;
      2'd1:    mem_n = 3'd2;
      default: mem_n = 3'd4;
    endcase
  end

`ifdef MEMCTRL_MISALIGN_CHK_EN
  logic misaligned;
  assign misaligned = ((mem_len_i == 2'd1) && mem_addr_i[0]) ||
                      (mem_len_i[1] && (mem_addr_i[1:0] != 2'b00));
`endif

  // The RAM byte arriving now belongs to the address issued one cycle earlier (index count-1).
  always_comb begin
    rword = rbuf;
    case (count)
      3'd1:    rword[7:0]   = ram_din_i;
      3'd2:    rword[15:8]  = ram_din_i;
      3'd3:    rword[23:16] = ram_din_i;
      3'd4:    rword[31:24] = ram_din_i;
      default: rword = rbuf;
    endcase
  end

  always_comb begin
    case (n_bytes)
      3'd1:    rext = {{24{sgn_q & rword[7]}}, rword[7:0]};
      3'd2:    rext = {{16{sgn_q & rword[15]}}, rword[15:0]};
      default: rext = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= 3'd0;
      n_bytes     <= 3'd0;
      cur_addr    <= 32'd0;
      rbuf        <= 32'd0;
      wdata_q     <= 24'd0;
      sgn_q       <= 1'b0;
      if_done_o   <= 1'b0;
      if_inst_o   <= 32'd0;
      mem_done_o  <= 1'b0;
      mem_rdata_o <= 32'd0;
      ram_addr_o  <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= 8'd0;
`ifdef MEMCTRL_MISALIGN_CHK_EN
      mem_misalign_o <= 1'b0;
`endif
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      ram_wr_o   <= 1'b0;
`ifdef MEMCTRL_MISALIGN_CHK_EN
      mem_misalign_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          count <= 3'd0;
          rbuf  <= 32'd0;
          if (mem_req_i) begin
`ifdef MEMCTRL_MISALIGN_CHK_EN
            if (misaligned) begin
              state          <= DONE;
              mem_done_o     <= 1'b1;
              mem_misalign_o <= 1'b1;
              mem_rdata_o    <= 32'd0;
            end else
`endif
            begin
              cur_addr   <= mem_addr_i;
              ram_addr_o <= mem_addr_i[RAM_ADDR_WIDTH-1:0];
              n_bytes    <= mem_n;
              sgn_q      <= mem_signed_i;
              wdata_q    <= mem_wdata_i[31:8];
              if (mem_we_i) begin
                state      <= MEM_WR;
                ram_wr_o   <= 1'b1;
                ram_dout_o <= mem_wdata_i[7:0];
              end else begin
                state <= MEM_RD;
              end
            end
          end else if (if_req_i) begin
            cur_addr   <= if_addr_i;
            ram_addr_o <= if_addr_i[RAM_ADDR_WIDTH-1:0];
            n_bytes    <= 3'd4;
            sgn_q      <= 1'b0;
            state      <= IF_RD;
          end
        end

        // Reads issue N addresses and need one extra cycle to catch the last byte.
        IF_RD, MEM_RD: begin
          rbuf  <= rword;
          count <= count + 3'd1;
          if (count == n_bytes) begin
            state <= DONE;
            if (state == IF_RD) begin
              if_done_o <= 1'b1;
              if_inst_o <= rext;
            end else begin
              mem_done_o  <= 1'b1;
              mem_rdata_o <= rext;
            end
          end else if (count + 3'd1 < n_bytes) begin
            cur_addr   <= next_addr;
            ram_addr_o <= next_addr[RAM_ADDR_WIDTH-1:0];
          end
        end

        MEM_WR: begin
          if (count + 3'd1 == n_bytes) begin
            state      <= DONE;
            mem_done_o <= 1'b1;
          end else begin
            count      <= count + 3'd1;
            cur_addr   <= next_addr;
            ram_addr_o <= next_addr[RAM_ADDR_WIDTH-1:0];
            ram_wr_o   <= 1'b1;
            ram_dout_o <= wdata_q[7:0];
            wdata_q    <= {8'd0, wdata_q[23:8]};
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  // Done pulses are exclusive, only appear in DONE, and the RAM is only written by a store.
  a_done_onehot: assert property (@(posedge clk) disable iff (rst) !(if_done_o && mem_done_o));
  a_done_state:  assert property (@(posedge clk) disable iff (rst) (if_done_o || mem_done_o) |-> state == DONE);
  a_wr_in_store: assert property (@(posedge clk) disable iff (rst) ram_wr_o |-> state == MEM_WR);

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, hand-written corner sequences,
// then random traffic checked against a byte-array reference model.
module tb_mem_ctrl;

  localparam int AW = 17;
  localparam int RAM_SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [31:0]   if_addr_i;
  logic          if_busy_o;
  logic          if_done_o;
  logic [31:0]   if_inst_o;
  logic          mem_req_i;
  logic          mem_we_i;
  logic [1:0]    mem_len_i;
  logic          mem_signed_i;
  logic [31:0]   mem_addr_i;
  logic [31:0]   mem_wdata_i;
  logic          mem_busy_o;
  logic          mem_done_o;
  logic [31:0]   mem_rdata_o;
`ifdef MEMCTRL_MISALIGN_CHK_EN
  logic          mem_misalign_o;
`endif
  logic [AW-1:0] ram_addr_o;
  logic          ram_wr_o;
  logic [7:0]    ram_dout_o;
  logic [7:0]    ram_din_i;

  mem_ctrl #(.RAM_ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_busy_o    (if_busy_o),
    .if_done_o    (if_done_o),
    .if_inst_o    (if_inst_o),
    .mem_req_i    (mem_req_i),
    .mem_we_i     (mem_we_i),
    .mem_len_i    (mem_len_i),
    .mem_signed_i (mem_signed_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_busy_o   (mem_busy_o),
    .mem_done_o   (mem_done_o),
    .mem_rdata_o  (mem_rdata_o),
`ifdef MEMCTRL_MISALIGN_CHK_EN
    .mem_misalign_o (mem_misalign_o),
`endif
    .ram_addr_o   (ram_addr_o),
    .ram_wr_o     (ram_wr_o),
    .ram_dout_o   (ram_dout_o),
    .ram_din_i    (ram_din_i)
  );

  always #5 clk = ~clk;

  logic [7:0] ram     [RAM_SIZE];
  logic [7:0] ref_mem [RAM_SIZE];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;
  wr_t wr_log[$];

  // Synchronous RAM with one cycle read latency; every write is logged with its cycle number.
  always @(posedge clk) begin
    ram_din_i <= ram[ram_addr_o];
    if (ram_wr_o) begin
      ram[ram_addr_o] = ram_dout_o;
      wr_log.push_back('{cyc, ram_addr_o, ram_dout_o});
    end
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [7:0] b);
    ram[addr[AW-1:0]] = b;
    ref_mem[addr[AW-1:0]] = b;
  endtask

  // Reference model: byte array indexed by truncated 32-bit wrap-around addresses.
  task automatic modelTxn(input logic is_if, input logic we, input logic [1:0] len, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] exp_data, output int exp_lat, output int exp_wr,
                          output logic exp_mis);
    int n;
    logic [31:0] a;
    logic [31:0] mask;
    n = is_if ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
    exp_mis = 1'b0;
    exp_data = 32'd0;
    exp_wr = 0;
`ifdef MEMCTRL_MISALIGN_CHK_EN
    if (!is_if && (addr % n) != 0) exp_mis = 1'b1;
`endif
    if (exp_mis) begin
      exp_lat = 1;
    end else if (!is_if && we) begin
      for (int k = 0; k < n; k++) begin
        a = addr + k;
        ref_mem[a[AW-1:0]] = 8'((wdata >> (8 * k)) & 32'hFF);
      end
      exp_lat = n + 1;
      exp_wr = n;
    end else begin
      for (int k = 0; k < n; k++) begin
        a = addr + k;
        exp_data = exp_data | (32'(ref_mem[a[AW-1:0]]) << (8 * k));
      end
      if (!is_if && sgn && n < 4 && exp_data[8 * n - 1]) begin
        mask = (32'h1 << (8 * n)) - 32'h1;
        exp_data = exp_data | ~mask;
      end
      exp_lat = n + 2;
    end
  endtask

  // Raises one request during the current cycle T and waits (bounded) for its done pulse.
  task automatic applyStimulus(input logic is_if, input logic we, input logic [1:0] len, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] data, output int lat, output int busy_cycles,
                               output int t0, output logic mis);
    if (is_if) begin
      if_req_i = 1'b1;
      if_addr_i = addr;
    end else begin
      mem_req_i = 1'b1;
      mem_we_i = we;
      mem_len_i = len;
      mem_signed_i = sgn;
      mem_addr_i = addr;
      mem_wdata_i = wdata;
    end
    lat = 0;
    busy_cycles = 0;
    t0 = -1;
    forever begin
      @(negedge clk);
      if (t0 < 0) t0 = cyc;
      if (is_if ? if_busy_o : mem_busy_o) busy_cycles++;
      if (is_if ? if_done_o : mem_done_o) break;
      lat++;
      if (lat > 40) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL done timeout: got no done after %0d cycles, expected a done pulse", lat);
        break;
      end
    end
    data = is_if ? if_inst_o : mem_rdata_o;
`ifdef MEMCTRL_MISALIGN_CHK_EN
    mis = is_if ? 1'b0 : mem_misalign_o;
`else
    mis = 1'b0;
`endif
    @(posedge clk); #1;
    if_req_i = 1'b0;
    mem_req_i = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        is_if;
    logic        we;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [15];
  logic [31:0] got, exp_data, last_if, last_mem;
  logic        mis, exp_mis, have_if, have_mem;
  int          lat, busy, t0, k, pulses, wrs, exp_lat, exp_wr;
  logic        r_if, r_we, r_sgn;
  logic [1:0]  r_len;
  logic [31:0] r_addr, r_wdata;

  initial begin
    rst = 1'b1;
    if_req_i = 1'b0;
    if_addr_i = 32'd0;
    mem_req_i = 1'b0;
    mem_we_i = 1'b0;
    mem_len_i = 2'd0;
    mem_signed_i = 1'b0;
    mem_addr_i = 32'd0;
    mem_wdata_i = 32'd0;
    for (int i = 0; i < RAM_SIZE; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'h00); poke(32'h1003, 8'h00);
    poke(32'h0010, 8'h80);
    poke(32'h0020, 8'h34); poke(32'h0021, 8'h92);
    poke(32'h1FFFF, 8'hAA); poke(32'h0000, 8'hBB); poke(32'h0001, 8'hCC); poke(32'h0002, 8'hDD);
    poke(32'h2000, 8'h78); poke(32'h2001, 8'h56); poke(32'h2002, 8'h34); poke(32'h2003, 8'h12);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset if_done", 32'(if_done_o), 32'd0);
    checkOutput("reset mem_done", 32'(mem_done_o), 32'd0);
    checkOutput("reset ram_wr", 32'(ram_wr_o), 32'd0);
    checkOutput("reset ram_addr", 32'(ram_addr_o), 32'd0);
    checkOutput("reset ram_dout", 32'(ram_dout_o), 32'd0);
    checkOutput("reset if_inst", if_inst_o, 32'd0);
    checkOutput("reset mem_rdata", mem_rdata_o, 32'd0);
`ifdef MEMCTRL_MISALIGN_CHK_EN
    checkOutput("reset misalign", 32'(mem_misalign_o), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    //            if   we    len   sgn   addr          wdata         chk   exp_data      lat
    vecs[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h00001000, 32'h0,        1'b1, 32'h00000513, 6};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h00000010, 32'h0,        1'b1, 32'hFFFFFF80, 3};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h00000010, 32'h0,        1'b1, 32'h00000080, 3};
    vecs[3]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h00000020, 32'h0,        1'b1, 32'hFFFF9234, 4};
    vecs[4]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h00000020, 32'h0,        1'b1, 32'h00009234, 4};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1, 32'hDDCCBBAA, 6};
    vecs[6]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h00021000, 32'h0,        1'b1, 32'h00000513, 6};
    vecs[7]  = '{1'b0, 1'b0, 2'd3, 1'b0, 32'h00001000, 32'h0,        1'b1, 32'h00000513, 6};
    vecs[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h00000040, 32'hCAFEF00D, 1'b0, 32'h0,        5};
    vecs[9]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h00000040, 32'h0,        1'b1, 32'hCAFEF00D, 6};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h00000044, 32'h000000A5, 1'b0, 32'h0,        2};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h00000044, 32'h0,        1'b1, 32'hFFFFFFA5, 3};
    vecs[12] = '{1'b0, 1'b0, 2'd2, 1'b1, 32'h00000040, 32'h0,        1'b1, 32'hCAFEF00D, 6};
    vecs[13] = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h00000042, 32'h0,        1'b1, 32'hFFFFCAFE, 4};
    vecs[14] = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h00001000, 32'h0,        1'b1, 32'h00000013, 3};

    for (int i = 0; i < 15; i++) begin
      modelTxn(vecs[i].is_if, vecs[i].we, vecs[i].len, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
               exp_data, exp_lat, exp_wr, exp_mis);
      applyStimulus(vecs[i].is_if, vecs[i].we, vecs[i].len, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                    got, lat, busy, t0, mis);
      if (vecs[i].chk) checkOutput($sformatf("vec%0d data", i), got, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("vec%0d busy cycles", i), 32'(busy), 32'(vecs[i].exp_lat));
    end

    // Store halfword: two byte writes on consecutive cycles, done right after.
    wr_log.delete();
    modelTxn(1'b0, 1'b1, 2'd1, 1'b0, 32'h2, 32'h1234BEEF, exp_data, exp_lat, exp_wr, exp_mis);
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 32'h2, 32'h1234BEEF, got, lat, busy, t0, mis);
    checkOutput("sh latency", 32'(lat), 32'd3);
    checkOutput("sh write count", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      checkOutput("sh wr0 cycle", 32'(wr_log[0].cyc - t0), 32'd1);
      checkOutput("sh wr0 addr", 32'(wr_log[0].addr), 32'h2);
      checkOutput("sh wr0 data", 32'(wr_log[0].data), 32'hEF);
      checkOutput("sh wr1 cycle", 32'(wr_log[1].cyc - t0), 32'd2);
      checkOutput("sh wr1 addr", 32'(wr_log[1].addr), 32'h3);
      checkOutput("sh wr1 data", 32'(wr_log[1].data), 32'hBE);
    end

    // Simultaneous requests: MEM is served first, IF is picked up in the following IDLE.
    if_req_i = 1'b1; if_addr_i = 32'h1000;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'd2; mem_signed_i = 1'b0; mem_addr_i = 32'h2000;
    lat = 0;
    forever begin
      @(negedge clk);
      if (mem_done_o) break;
      lat++;
      if (lat > 40) begin
        vectors++; miscompares++;
        $display("[TB] FAIL arb mem timeout: got no mem_done_o, expected one");
        break;
      end
    end
    checkOutput("arb mem latency", 32'(lat), 32'd6);
    checkOutput("arb mem data", mem_rdata_o, 32'h12345678);
    checkOutput("arb if_done during mem done", 32'(if_done_o), 32'd0);
    @(posedge clk); #1;
    mem_req_i = 1'b0;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (if_done_o) break;
      if (k > 40) begin
        vectors++; miscompares++;
        $display("[TB] FAIL arb if timeout: got no if_done_o, expected one");
        break;
      end
    end
    checkOutput("arb if gap", 32'(k), 32'd7);
    checkOutput("arb if data", if_inst_o, 32'h00000513);
    checkOutput("arb mem data held", mem_rdata_o, 32'h12345678);
    @(posedge clk); #1;
    if_req_i = 1'b0;
    @(posedge clk); #1;

    // Reset three cycles into a fetch aborts it without a done pulse.
    if_req_i = 1'b1; if_addr_i = 32'h1000;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; if_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst if_inst cleared", if_inst_o, 32'd0);
    checkOutput("rst ram_addr cleared", 32'(ram_addr_o), 32'd0);
    pulses = 0; wrs = 0;
    repeat (8) begin
      if (if_done_o) pulses++;
      if (ram_wr_o) wrs++;
      @(negedge clk);
    end
    checkOutput("rst no if_done", 32'(pulses), 32'd0);
    checkOutput("rst no ram_wr", 32'(wrs), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, got, lat, busy, t0, mis);
    checkOutput("post-rst fetch data", got, 32'h00000513);
    checkOutput("post-rst fetch latency", 32'(lat), 32'd6);

`ifdef MEMCTRL_MISALIGN_CHK_EN
    wr_log.delete();
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'h3, 32'hDEADBEEF, got, lat, busy, t0, mis);
    checkOutput("misalign sw latency", 32'(lat), 32'd1);
    checkOutput("misalign sw flag", 32'(mis), 32'd1);
    checkOutput("misalign sw rdata", got, 32'd0);
    checkOutput("misalign sw writes", 32'(wr_log.size()), 32'd0);
`endif

    // Random traffic against the reference model.
    have_if = 1'b0; have_mem = 1'b0; last_if = 32'd0; last_mem = 32'd0;
    for (int n = 0; n < 300; n++) begin
      r_if = ($urandom_range(0, 3) == 0);
      r_we = 1'($urandom);
      r_len = 2'($urandom);
      r_sgn = 1'($urandom);
      r_wdata = $urandom;
      if ($urandom_range(0, 7) == 0) r_addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      else r_addr = ($urandom & 32'hFFFE0000) | 32'($urandom_range(0, 63));
      modelTxn(r_if, r_we, r_len, r_sgn, r_addr, r_wdata, exp_data, exp_lat, exp_wr, exp_mis);
      wr_log.delete();
      applyStimulus(r_if, r_we, r_len, r_sgn, r_addr, r_wdata, got, lat, busy, t0, mis);
      if (r_if || !r_we || exp_mis) checkOutput($sformatf("rnd%0d data", n), got, exp_data);
      checkOutput($sformatf("rnd%0d latency", n), 32'(lat), 32'(exp_lat));
      checkOutput($sformatf("rnd%0d busy cycles", n), 32'(busy), 32'(exp_lat));
      checkOutput($sformatf("rnd%0d writes", n), 32'(wr_log.size()), 32'(exp_wr));
`ifdef MEMCTRL_MISALIGN_CHK_EN
      if (!r_if) checkOutput($sformatf("rnd%0d misalign", n), 32'(mis), 32'(exp_mis));
`endif
      if (r_if) begin
        if (have_mem) checkOutput($sformatf("rnd%0d mem_rdata held", n), mem_rdata_o, last_mem);
        have_if = 1'b1;
        last_if = exp_data;
      end else begin
        if (have_if) checkOutput($sformatf("rnd%0d if_inst held", n), if_inst_o, last_if);
        have_mem = !r_we || exp_mis;
        last_mem = exp_data;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
